// File: rtl/serial_bus_slave_pkg.sv
// Shared definitions for the serial bus slave: FSM state encoding and default bus widths.
package serial_bus_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_WCOMMIT = 3'd3,
        ST_RWAIT   = 3'd4,
        ST_RDATA   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_BURST_W = 4;

endpackage

// File: rtl/serial_bus_slave_mem.sv
// Single-port synchronous RAM with an RD_LAT-deep read pipeline; contents survive reset.
module slave_mem
    import serial_bus_slave_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = 4096,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Stage 0 only loads on a read, so dout holds the last word read until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (en && !we) begin
                pipe[0] <= mem[addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[RD_LAT-1];

endmodule

// File: rtl/serial_bus_slave.sv
// Bit-serial bus slave: LSB-first address/burst/write-data shift-in, LSB-first read data
// shift-out with incrementing bursts, programmable read delay and read back-pressure.
module serial_bus_slave
    import serial_bus_slave_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int MEM_DEPTH   = 4096,
    parameter int SLAVE_DELAY = 2,
    parameter int RD_LAT      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read_en,
    input  logic       write_en,
    input  logic       master_valid,
    input  logic       master_ready,
    output logic       slave_valid,
    output logic       slave_ready,
    input  logic       rx_address,
    input  logic       rx_data,
    input  logic       rx_burst,
    output logic       tx_data,
    output logic       rx_done,
    output logic       tx_done,
    output logic [2:0] state_dbg
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int DLY_W = $clog2(SLAVE_DELAY + RD_LAT + 1);

    localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   BURST_LIM = CNT_W'(BURST_W);
    localparam logic [DLY_W-1:0]   WAIT_LAST = DLY_W'(SLAVE_DELAY + RD_LAT);
    localparam logic [BURST_W:0]   LAST_BEAT = (BURST_W + 1)'(1);

    state_t              state;
    logic                mode_rd;
    logic [ADDR_W-1:0]   addr;
    logic [BURST_W-1:0]  burst_sh;
    logic [BURST_W:0]    beats_left;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DLY_W-1:0]    dly_cnt;
    logic [DATA_W-1:0]   wdata_sh;
    logic [DATA_W-1:0]   tx_shift;

    logic [ADDR_W:0]     addr_cat;
    logic [BURST_W:0]    burst_cat;
    logic [DATA_W:0]     wdata_cat;
    logic [ADDR_W-1:0]   addr_next;
    logic [BURST_W-1:0]  burst_next;
    logic [DATA_W-1:0]   wdata_next;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_dout;

    assign addr_cat   = {rx_address, addr};
    assign burst_cat  = {rx_burst, burst_sh};
    assign wdata_cat  = {rx_data, wdata_sh};
    assign addr_next  = addr_cat[ADDR_W:1];
    assign wdata_next = wdata_cat[DATA_W:1];
    assign burst_next = (bit_cnt < BURST_LIM) ? burst_cat[BURST_W:1] : burst_sh;
    assign state_dbg  = state;

    // Reads prefetch addr+1 during bit 0 of every beat so the next word is ready at the beat edge.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr;
        case (state)
            ST_WCOMMIT: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            ST_RWAIT: mem_en = (dly_cnt == '0);
            ST_RDATA: begin
                mem_en   = (bit_cnt == '0);
                mem_addr = addr + 1'b1;
            end
            default: ;
        endcase
    end

    slave_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_DEPTH(MEM_DEPTH),
        .RD_LAT   (RD_LAT)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (wdata_sh),
        .dout (mem_dout)
    );

    // Handshake: an rx bit is taken on a clock edge with master_valid=1 while slave_ready=1;
    // a tx bit is consumed on a clock edge with slave_valid=1 and master_ready=1, else it holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mode_rd     <= 1'b0;
            addr        <= '0;
            burst_sh    <= '0;
            beats_left  <= '0;
            bit_cnt     <= '0;
            dly_cnt     <= '0;
            wdata_sh    <= '0;
            tx_shift    <= '0;
            slave_valid <= 1'b0;
            slave_ready <= 1'b0;
            tx_data     <= 1'b0;
            rx_done     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    slave_ready <= 1'b1;
                    slave_valid <= 1'b0;
                    tx_data     <= 1'b0;
                    if (master_valid && (read_en ^ write_en)) begin
                        mode_rd <= read_en;
                        bit_cnt <= '0;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (master_valid) begin
                        addr     <= addr_next;
                        burst_sh <= burst_next;
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt    <= '0;
                            beats_left <= {1'b0, burst_next} + 1'b1;
                            if (mode_rd) begin
                                dly_cnt     <= '0;
                                slave_ready <= 1'b0;
                                state       <= ST_RWAIT;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (master_valid) begin
                        wdata_sh <= wdata_next;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt     <= '0;
                            slave_ready <= 1'b0;
                            state       <= ST_WCOMMIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_WCOMMIT: begin
                    if (beats_left != LAST_BEAT) begin
                        beats_left  <= beats_left - 1'b1;
                        addr        <= addr + 1'b1;
                        slave_ready <= 1'b1;
                        state       <= ST_WDATA;
                    end else begin
                        rx_done <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                // The wait spans the delay plus memory latency, and one more edge to load the word.
                ST_RWAIT: begin
                    if (dly_cnt == WAIT_LAST) begin
                        slave_valid <= 1'b1;
                        tx_data     <= mem_dout[0];
                        tx_shift    <= mem_dout >> 1;
                        bit_cnt     <= '0;
                        state       <= ST_RDATA;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (master_ready) begin
                        if (bit_cnt != DATA_LAST) begin
                            tx_data  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end else if (beats_left != LAST_BEAT) begin
                            beats_left <= beats_left - 1'b1;
                            addr       <= addr + 1'b1;
                            tx_data    <= mem_dout[0];
                            tx_shift   <= mem_dout >> 1;
                            bit_cnt    <= '0;
                        end else begin
                            slave_valid <= 1'b0;
                            tx_data     <= 1'b0;
                            tx_done     <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    slave_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_slave.sv
// Scoreboard bench for serial_bus_slave: expected read bits come from an array memory model.
module tb_serial_bus_slave;
    import serial_bus_slave_pkg::*;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int BURST_W     = 4;
    localparam int MEM_DEPTH   = 4096;
    localparam int SLAVE_DELAY = 2;
    localparam int RD_LAT      = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read_en = 1'b0;
    logic       write_en = 1'b0;
    logic       master_valid = 1'b0;
    logic       master_ready = 1'b0;
    logic       rx_address = 1'b0;
    logic       rx_data = 1'b0;
    logic       rx_burst = 1'b0;
    logic       slave_valid;
    logic       slave_ready;
    logic       tx_data;
    logic       rx_done;
    logic       tx_done;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;

    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    logic [DATA_W-1:0] wr_words[$];
    logic [0:0]        exp_q[$];

    serial_bus_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .MEM_DEPTH(MEM_DEPTH), .SLAVE_DELAY(SLAVE_DELAY), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .slave_valid(slave_valid), .slave_ready(slave_ready),
        .rx_address(rx_address), .rx_data(rx_data), .rx_burst(rx_burst),
        .tx_data(tx_data), .rx_done(rx_done), .tx_done(tx_done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (rx_done) rx_done_cnt++;
            if (tx_done) tx_done_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(slave_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_bit));
            end
            if (slave_valid && master_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %0b with empty queue, required no bit", tx_data);
                end else begin
                    check("tx_bit", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = slave_valid && !master_ready;
            prev_bit   = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // drivers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input bit rd, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                               input int stall_at, input int stall_len, input bit rnd);
        logic [ADDR_W-1:0] bx;
        bx = ADDR_W'(b);
        read_en = rd;
        write_en = !rd;
        master_valid = 1'b1;
        cyc();
        read_en = 1'b0;
        write_en = 1'b0;
        for (int i = 0; i < ADDR_W; i++) begin
            int n;
            n = (i == stall_at) ? stall_len : 0;
            if (rnd && $urandom_range(0, 3) == 0) n = $urandom_range(1, 2);
            for (int s = 0; s < n; s++) begin
                master_valid = 1'b0;
                rx_address = 1'($urandom);
                rx_burst = 1'($urandom);
                cyc();
            end
            master_valid = 1'b1;
            rx_address = a[i];
            rx_burst = (i < BURST_W) ? bx[i] : 1'($urandom);
            cyc();
        end
        master_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                            input int stall_at, input int stall_len, input bit rnd);
        int rx0;
        rx0 = rx_done_cnt;
        send_header(1'b0, a, b, stall_at, stall_len, rnd);
        for (int beat = 0; beat <= int'(b); beat++) begin
            logic [ADDR_W-1:0] wa;
            wa = a + ADDR_W'(beat);
            for (int i = 0; i < DATA_W; i++) begin
                if (rnd && $urandom_range(0, 4) == 0) begin
                    master_valid = 1'b0;
                    rx_data = 1'($urandom);
                    cyc();
                end
                master_valid = 1'b1;
                rx_data = wr_words[beat][i];
                cyc();
            end
            master_valid = 1'b0;
            @(negedge clk);
            check("wcommit_ready", 32'(slave_ready), 32'd0);
            ref_mem[wa] = wr_words[beat];
            cyc();
        end
        @(negedge clk);
        check("rx_done_pulse", 32'(rx_done), 32'd1);
        cyc();
        @(negedge clk);
        check("idle_ready_after_write", 32'(slave_ready), 32'd1);
        check("rx_done_once", 32'(rx_done_cnt - rx0), 32'd1);
        cyc();
    endtask

    // mode 0: always ready, 1: random back-pressure, 2: ready low for 3 cycles at bit 4
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                           input int mode, input int abort_at);
        int tx0, k, bits, acc, n, gaps, stall_left;
        tx0 = tx_done_cnt;
        for (int beat = 0; beat <= int'(b); beat++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] w;
            ra = a + ADDR_W'(beat);
            w = ref_mem[ra];
            for (int i = 0; i < DATA_W; i++) exp_q.push_back(w[i]);
        end
        send_header(1'b1, a, b, -1, 0, mode == 1);
        master_ready = 1'b0;
        k = 0;
        @(negedge clk);
        check("rwait_ready", 32'(slave_ready), 32'd0);
        while (!slave_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("read_latency", 32'(k), 32'(SLAVE_DELAY + RD_LAT + 1));
        bits = (int'(b) + 1) * DATA_W;
        acc = 0;
        n = 0;
        gaps = 0;
        stall_left = 3;
        while (acc < bits && n < bits * 8 + 20) begin
            @(posedge clk);
            #1;
            case (mode)
                0: master_ready = 1'b1;
                1: master_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (acc == 4 && stall_left > 0) begin
                        master_ready = 1'b0;
                        stall_left--;
                    end else begin
                        master_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            n++;
            if (abort_at >= 0 && acc == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_slave_valid", 32'(slave_valid), 32'd0);
                check("rst_slave_ready", 32'(slave_ready), 32'd0);
                check("rst_tx_data", 32'(tx_data), 32'd0);
                check("rst_done_pulses", 32'({rx_done, tx_done}), 32'd0);
                check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
                exp_q.delete();
                master_ready = 1'b0;
                return;
            end
            if (!slave_valid) gaps++;
            if (slave_valid && master_ready) acc++;
        end
        check("read_bits_accepted", 32'(acc), 32'(bits));
        check("read_valid_gaps", 32'(gaps), 32'd0);
        if (mode == 0) check("gapless_cycles", 32'(n), 32'(bits));
        if (mode == 2) check("stall_cycles", 32'(n), 32'(bits + 3));
        cyc();
        master_ready = 1'b0;
        @(negedge clk);
        check("tx_done_pulse", 32'(tx_done), 32'd1);
        check("done_valid_low", 32'(slave_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("idle_ready_after_read", 32'(slave_ready), 32'd1);
        check("tx_done_once", 32'(tx_done_cnt - tx0), 32'd1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        cyc();
    endtask

    task automatic fill_words(input int beats);
        wr_words.delete();
        for (int i = 0; i < beats; i++) wr_words.push_back(DATA_W'($urandom));
    endtask

    initial begin
        // reset state
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_slave_ready", 32'(slave_ready), 32'd0);
        check("reset_slave_valid", 32'(slave_valid), 32'd0);
        check("reset_outputs", 32'({tx_data, rx_done, tx_done}), 32'd0);
        reset = 1'b1;
        #1;
        check("release_ready_before_edge", 32'(slave_ready), 32'd0);
        cyc();
        check("release_ready_after_edge", 32'(slave_ready), 32'd1);
        check("release_state", 32'(state_dbg), 32'(ST_IDLE));

        // single word write / read
        wr_words.delete();
        wr_words.push_back(8'hA5);
        do_write(12'h005, 4'd0, -1, 0, 1'b0);
        do_read(12'h005, 4'd0, 0, -1);

        // burst across the top of memory
        wr_words.delete();
        wr_words.push_back(8'h11);
        wr_words.push_back(8'h22);
        wr_words.push_back(8'h33);
        wr_words.push_back(8'h44);
        do_write(12'hFFE, 4'd3, -1, 0, 1'b0);
        do_read(12'hFFE, 4'd3, 0, -1);
        do_read(12'h000, 4'd0, 0, -1);
        do_read(12'h001, 4'd0, 0, -1);

        // back-pressure at bit 4
        do_read(12'h005, 4'd0, 2, -1);

        // address stall
        wr_words.delete();
        wr_words.push_back(8'h3C);
        do_write(12'h123, 4'd0, 6, 2, 1'b0);
        do_read(12'h123, 4'd0, 0, -1);

        // conflicting / absent enables are ignored
        read_en = 1'b1;
        write_en = 1'b1;
        master_valid = 1'b1;
        repeat (3) cyc();
        check("both_en_state", 32'(state_dbg), 32'(ST_IDLE));
        check("both_en_ready", 32'(slave_ready), 32'd1);
        read_en = 1'b0;
        write_en = 1'b0;
        repeat (2) cyc();
        check("no_en_state", 32'(state_dbg), 32'(ST_IDLE));
        master_valid = 1'b0;
        cyc();
        do_read(12'h005, 4'd0, 1, -1);

        // reset mid-read, memory retained
        do_read(12'hFFE, 4'd3, 0, 10);
        repeat (2) cyc();
        check("held_reset_ready", 32'(slave_ready), 32'd0);
        reset = 1'b1;
        cyc();
        check("post_reset_ready", 32'(slave_ready), 32'd1);
        do_read(12'hFFE, 4'd3, 1, -1);

        // maximum burst field
        fill_words(16);
        do_write(12'hFF8, 4'd15, -1, 0, 1'b1);
        do_read(12'hFF8, 4'd15, 1, -1);

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            logic [ADDR_W-1:0] ra;
            logic [BURST_W-1:0] rb;
            ra = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
            rb = BURST_W'($urandom_range(0, 3));
            fill_words(int'(rb) + 1);
            do_write(ra, rb, -1, 0, 1'b1);
            do_read(ra, rb, $urandom_range(0, 1), -1);
        end

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
